// File: rtl/adder_tree_mlane.sv
// Multi-lane sequential adder tree: reduces KERNEL_SIZE product terms to one sum,
// LANES terms per beat, with valid/ready handshakes on input and output.
module adder_tree_mlane #(
  parameter int KERNEL_SIZE  = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 1,
  parameter int LANES        = 4,
  parameter int SIGNED       = 0,
  localparam int TERM_W      = DATA_WIDTH + WEIGHT_WIDTH,
  localparam int OUT_W       = TERM_W + $clog2(KERNEL_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TERM_W*KERNEL_SIZE-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          busy
);

  localparam int BEATS  = (KERNEL_SIZE + LANES - 1) / LANES;
  localparam int PAD_W  = BEATS * LANES * TERM_W;
  localparam int SHIFT  = LANES * TERM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   cap_q, cap_d;
  logic [PAD_W-1:0]   in_pad;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;
  logic [OUT_W-1:0]   lane_sum;
  logic [OUT_W-1:0]   lane_ext  [LANES];
  logic [OUT_W-1:0]   sum_chain [LANES+1];

  // Zero padding past the last term makes the tail lanes of the final beat add nothing.
  assign in_pad = PAD_W'(in_data);

  // The capture register shifts down by one beat each cycle, so the active lanes
  // always sit in its lowest LANES term slots.
  assign sum_chain[0] = '0;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [TERM_W-1:0] term;
    assign term = cap_q[gi*TERM_W +: TERM_W];
    if (SIGNED != 0) begin : g_sext
      assign lane_ext[gi] = OUT_W'($signed(term));
    end else begin : g_zext
      assign lane_ext[gi] = OUT_W'(term);
    end
    assign sum_chain[gi+1] = sum_chain[gi] + lane_ext[gi];
  end
  assign lane_sum = sum_chain[LANES];

  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == S_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cap_d   = in_pad;
          acc_d   = '0;
          beat_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d  = acc_q + lane_sum;
        cap_d  = cap_q >> SHIFT;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_LAST) begin
          out_data_d  = acc_q + lane_sum;
          out_valid_d = 1'b1;
          beat_d      = '0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Back-to-back: the next kernel is taken in the same cycle as the result.
          if (accept) begin
            cap_d   = in_pad;
            acc_d   = '0;
            beat_d  = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cap_q       <= '0;
      acc_q       <= '0;
      beat_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
